// File: rtl/cpu_pkg.sv
// Shared types and sizing for the CPU run controller.
package cpu_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = $clog2(NUM_REGS);
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Load/run/dump sequencer: streams a program into IMEM, runs the CPU until
// halt or watchdog expiry, then streams out the whole register file.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_AW    = 10,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load_valid,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_rst,
  output logic               cpu_en,
  input  logic               cpu_halt,
  output logic [REG_AW-1:0]  rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               dump_valid,
  output logic [REG_AW-1:0]  dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  input  logic               dump_ready,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               load_full,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam logic [IMEM_AW-1:0] ADDR_MAX = '1;
  localparam logic [REG_AW-1:0]  REG_LAST = REG_AW'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_CYCLES);

  run_state_e         state_q, state_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [REG_AW-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               full_q, full_d;
  logic               done_q, done_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      full_q    <= full_d;
      done_q    <= done_d;
    end
  end

  // Next-state, next-datapath and control outputs; reset overrides controls.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    full_d     = full_q;
    done_d     = done_q;
    load_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_rst    = 1'b1;
    cpu_en     = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD;
          addr_d    = '0;
          idx_d     = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
          full_d    = 1'b0;
          done_d    = 1'b0;
        end
      end

      ST_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_valid) begin
          imem_we = 1'b1;
          if (load_last) begin
            state_d = ST_RUN;
          end else if (addr_q == ADDR_MAX) begin
            // Memory is full: stop loading without wrapping the address.
            full_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            addr_d = addr_q + IMEM_AW'(1);
          end
        end
      end

      ST_RUN: begin
        cpu_rst = 1'b0;
        cpu_en  = 1'b1;
        busy    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Halt takes priority over a watchdog expiry in the same cycle.
        if (cpu_halt) begin
          state_d   = ST_DUMP;
          timeout_d = 1'b0;
          idx_d     = '0;
        end else if (cnt_d >= CNT_MAX) begin
          state_d   = ST_DUMP;
          timeout_d = 1'b1;
          idx_d     = '0;
        end
      end

      ST_DUMP: begin
        cpu_rst    = 1'b0;
        busy       = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == REG_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + REG_AW'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      load_ready = 1'b0;
      imem_we    = 1'b0;
      cpu_rst    = 1'b1;
      cpu_en     = 1'b0;
      dump_valid = 1'b0;
      busy       = 1'b0;
    end
  end

  assign imem_addr   = addr_q;
  assign imem_wdata  = load_data;
  assign rf_raddr    = idx_q;
  assign dump_addr   = idx_q;
  assign dump_data   = rf_rdata;
  assign cycle_count = cnt_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign load_full   = full_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with IMEM write and register-dump scoreboards.
module tb_cpu_run_ctrl;
  import cpu_pkg::*;

  localparam int unsigned AW   = 2;
  localparam int unsigned MAXC = 50;

  logic              clk = 1'b0;
  logic              rst, start, load_valid, load_last, cpu_halt, dump_ready;
  logic [31:0]       load_data;
  logic              load_ready, imem_we, cpu_rst, cpu_en, dump_valid;
  logic [AW-1:0]     imem_addr;
  logic [31:0]       imem_wdata, rf_rdata, dump_data, cycle_count;
  logic [4:0]        rf_raddr, dump_addr;
  logic              busy, done, timeout, load_full;

  int checks = 0;
  int errors = 0;
  logic [63:0] imem_q[$];
  logic [63:0] dump_q[$];

  always #5 clk = ~clk;

  // Register file model: every register holds index*3.
  assign rf_rdata = 32'(rf_raddr) * 32'd3;

  cpu_run_ctrl #(.IMEM_AW(AW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
    .cpu_halt(cpu_halt), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_ready(dump_ready), .busy(busy), .done(done), .timeout(timeout),
    .load_full(load_full), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard checks at the falling edge, return just after the rising edge.
  task automatic step();
    logic [63:0] e;
    @(negedge clk);
    if (imem_we) begin
      e = (imem_q.size() != 0) ? imem_q.pop_front() : '1;
      chk("imem_write", 64'({imem_addr, imem_wdata}), e);
    end
    if (dump_valid) begin
      e = (dump_q.size() != 0) ? dump_q[0] : '1;
      chk("dump_beat", 64'({dump_addr, dump_data}), e);
      if (dump_ready && dump_q.size() != 0) void'(dump_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last,
                           input logic [AW-1:0] a, input bit accept);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    if (accept) imem_q.push_back(64'({a, d}));
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic push_dump(input int n);
    for (int k = 0; k < n; k++) dump_q.push_back(64'({5'(k), 32'(k * 3)}));
  endtask

  // Drain the dump with ready toggling every cycle, bounded.
  task automatic run_dump(input bit toggle);
    for (int k = 0; k < 200 && !done; k++) begin
      dump_ready = toggle ? ((k % 2) == 1) : 1'b1;
      step();
    end
    dump_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; cpu_halt = 1'b0; dump_ready = 1'b0;
    step(); step();
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_count", 64'(cycle_count), 64'd0);
    chk("idle_dump_valid", 64'(dump_valid), 64'd0);

    // Program of 4 words, halt on RUN cycle 10, dump with stalls.
    pulse_start();
    chk("load_ready", 64'(load_ready), 64'd1);
    chk("load_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("load_cpu_en", 64'(cpu_en), 64'd0);
    chk("load_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) load_word(32'hA000 + 32'(i), i == 3, AW'(i), 1'b1);
    chk("imem_all_written", 64'(imem_q.size()), 64'd0);
    chk("run_cpu_en", 64'(cpu_en), 64'd1);
    chk("run_cpu_rst", 64'(cpu_rst), 64'd0);
    for (int i = 1; i < 10; i++) begin
      start = (i == 5);
      step();
    end
    start = 1'b0;
    chk("run_count9", 64'(cycle_count), 64'd9);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("halt_count", 64'(cycle_count), 64'd10);
    chk("halt_timeout", 64'(timeout), 64'd0);
    chk("dump_valid", 64'(dump_valid), 64'd1);
    chk("dump_cpu_en", 64'(cpu_en), 64'd0);
    push_dump(32);
    run_dump(1'b1);
    chk("dump_drained", 64'(dump_q.size()), 64'd0);
    chk("done", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("done_count_hold", 64'(cycle_count), 64'd10);

    // Watchdog expiry with no halt.
    pulse_start();
    chk("restart_done_clr", 64'(done), 64'd0);
    chk("restart_count_clr", 64'(cycle_count), 64'd0);
    load_word(32'h1111, 1'b0, AW'(0), 1'b1);
    load_word(32'h2222, 1'b1, AW'(1), 1'b1);
    for (int i = 1; i < 50; i++) step();
    chk("wd_count49", 64'(cycle_count), 64'd49);
    chk("wd_still_run", 64'(cpu_en), 64'd1);
    step();
    chk("wd_count", 64'(cycle_count), 64'd50);
    chk("wd_timeout", 64'(timeout), 64'd1);
    chk("wd_dump_valid", 64'(dump_valid), 64'd1);
    push_dump(32);
    run_dump(1'b0);
    chk("wd_done", 64'(done), 64'd1);
    chk("wd_timeout_hold", 64'(timeout), 64'd1);

    // Halt coincides with watchdog limit; then reset mid-dump at index 7.
    pulse_start();
    chk("restart_timeout_clr", 64'(timeout), 64'd0);
    load_word(32'h3333, 1'b1, AW'(0), 1'b1);
    for (int i = 1; i < 50; i++) step();
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("tie_count", 64'(cycle_count), 64'd50);
    chk("tie_timeout", 64'(timeout), 64'd0);
    push_dump(7);
    dump_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("dump_idx7", 64'(dump_addr), 64'd7);
    rst = 1'b1;
    dump_ready = 1'b0;
    step();
    chk("dumprst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("dumprst_dump_valid", 64'(dump_valid), 64'd0);
    chk("dumprst_count", 64'(cycle_count), 64'd0);
    rst = 1'b0;
    step();
    chk("after_rst_busy", 64'(busy), 64'd0);
    chk("after_rst_dump_valid", 64'(dump_valid), 64'd0);
    chk("after_rst_addr", 64'(dump_addr), 64'd0);
    chk("dump7_drained", 64'(dump_q.size()), 64'd0);

    // Memory fills with 4 words; the 5th is offered but not accepted.
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        chk("full_flag", 64'(load_full), 64'd1);
        chk("full_no_ready", 64'(load_ready), 64'd0);
      end
      load_valid = 1'b1;
      load_data  = 32'hB0 + 32'(i);
      load_last  = 1'b0;
      if (i < 4) imem_q.push_back(64'({AW'(i), 32'hB0 + 32'(i)}));
      step();
    end
    load_valid = 1'b0;
    chk("full_writes", 64'(imem_q.size()), 64'd0);
    chk("full_addr_nowrap", 64'(imem_addr), 64'd3);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("full_count", 64'(cycle_count), 64'd2);
    chk("full_hold", 64'(load_full), 64'd1);
    push_dump(32);
    run_dump(1'b0);
    chk("full_done", 64'(done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter IMEM_AW, default 10, SHALL set the instruction-memory word-address width.
REQ-002 Parameter MAX_CYCLES, default 100000, SHALL set the RUN-phase watchdog limit in cycles.
REQ-003 clk  in  1  SHALL be the single clock; all logic updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 start  in  1  SHALL be the single-cycle request to begin a load/run/dump sequence.
REQ-006 load_valid, load_data[31:0], load_last  in  1/32/1  SHALL be the host program-word stream, with load_last marking the final word.
REQ-007 load_ready  out  1  SHALL indicate acceptance of a program word.
REQ-008 imem_we, imem_addr[IMEM_AW-1:0], imem_wdata[31:0]  out  SHALL form the instruction-memory write port.
REQ-009 cpu_rst  out  1 and cpu_en  out  1  SHALL hold the CPU in reset and enable CPU state updates, respectively.
REQ-010 cpu_halt  in  1  SHALL be the CPU halt indication.
REQ-011 rf_raddr[4:0]  out and rf_rdata[31:0]  in  SHALL form a combinational register-file debug read port.
REQ-012 dump_valid, dump_addr[4:0], dump_data[31:0]  out and dump_ready  in  SHALL form the register-dump stream.
REQ-013 busy, done, timeout, load_full  out  1 and cycle_count[31:0]  out  SHALL report status.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN, DUMP and DONE.
REQ-015 IDLE/DONE: a start pulse SHALL move to LOAD, clearing the load address, cycle_count, timeout, load_full and done; start SHALL be ignored in all other states.
REQ-016 LOAD: load_ready=1, cpu_rst=1, cpu_en=0; each cycle with load_valid&load_ready SHALL drive imem_we=1, imem_wdata=load_data and imem_addr=current address in that same cycle, then increment the address.
REQ-017 An accepted word with load_last=1 SHALL move to RUN on the next cycle.
REQ-018 An accepted word at address 2^IMEM_AW-1 without load_last SHALL set load_full=1 and move to RUN; the address SHALL NOT wrap.
REQ-019 RUN: cpu_rst=0, cpu_en=1; cycle_count SHALL increment once per RUN cycle.
REQ-020 RUN: cpu_halt=1 SHALL move to DUMP with timeout=0; cycle_count reaching MAX_CYCLES SHALL move to DUMP with timeout=1; if both occur in the same cycle, halt SHALL win (timeout=0).
REQ-021 DUMP: cpu_rst=0 and cpu_en=0, which freezes CPU state; dump_valid=1, rf_raddr=dump_addr=index, dump_data=rf_rdata.
REQ-022 In DUMP, each dump_valid&dump_ready SHALL increment the index; the handshake at index 31 SHALL move to DONE; dump_valid with dump_ready low SHALL hold index and data stable.
REQ-023 DONE: done=1, cpu_rst=1, cpu_en=0; status values SHALL hold until the next start.
REQ-024 busy SHALL equal 1 exactly in LOAD, RUN and DUMP.
REQ-025 load_valid outside LOAD SHALL have no effect, and imem_we SHALL be 0 outside LOAD.

Reset
REQ-026 rst=1 SHALL force IDLE from any state, including mid-LOAD, mid-RUN and mid-DUMP, on the next edge.
REQ-027 rst=1 SHALL clear the load address, index, cycle_count, timeout, load_full and done.
REQ-028 rst=1 SHALL drive cpu_rst=1 and cpu_en=load_ready=imem_we=dump_valid=busy=0.

Structure
REQ-029 The state enum, register count (32) and data width (32) SHALL live in the shared package cpu_pkg.
REQ-030 The block SHALL be a single module with no sub-module instantiations.

Verification
REQ-031 The bench SHALL cover: start; 4 words (last on word 3); halt asserted on RUN cycle 10 -> imem writes at addresses 0..3, then DUMP with cycle_count=10, timeout=0.
REQ-032 The bench SHALL cover: MAX_CYCLES=50 with halt never asserted -> DUMP entered with cycle_count=50 and timeout=1.
REQ-033 The bench SHALL cover: halt asserted in the same cycle that cycle_count reaches MAX_CYCLES -> timeout=0.
REQ-034 The bench SHALL cover: IMEM_AW=2 with 5 words offered and no load_last -> 4 words written, load_full=1, 5th word not accepted.
REQ-035 The bench SHALL cover: RF filled with value index*3 and dump_ready toggled every other cycle -> 32 transfers with data 0,3,...,93, stable while stalled, then done=1.
REQ-036 The bench SHALL cover: rst asserted in DUMP at index 7 -> IDLE, cpu_rst=1, dump_valid=0 on the next cycle.
